// File: rtl/brd_tx_ack_scheduler_if.sv
// Reply-source / frame-builder signals around brd_tx_ack_scheduler.
// master = scheduler side, slave = requesters and tx frame builder.
interface brd_tx_ack_scheduler_if #(
  parameter int unsigned NUM_REQ = 5
);
  logic               OUT_TICK;
  logic [NUM_REQ-1:0] REQ;
  logic               TX_DONE;
  logic               TX_BUSY;
  logic [NUM_REQ-1:0] GRANT;
  logic [2:0]         TX_SEL;
  logic               TX_START;
  logic [NUM_REQ-1:0] PENDING;
  logic               SCHED_BUSY;
  logic               TX_TIMEOUT;

  modport master (
    input  OUT_TICK, REQ, TX_DONE, TX_BUSY,
    output GRANT, TX_SEL, TX_START, PENDING, SCHED_BUSY, TX_TIMEOUT
  );

  modport slave (
    output OUT_TICK, REQ, TX_DONE, TX_BUSY,
    input  GRANT, TX_SEL, TX_START, PENDING, SCHED_BUSY, TX_TIMEOUT
  );
endinterface

// File: rtl/brd_tx_ack_scheduler.sv
// Round-robin scheduler granting the shared tx frame builder to reply sources.
// Optional STATUS_PRIO_EN: index 0 (status ack) wins ARB whenever it is pending.
module brd_tx_ack_scheduler #(
  parameter int unsigned NUM_REQ     = 5,
  parameter int unsigned GAP_TICKS   = 12,
  parameter int unsigned TIMEOUT_CYC = 2048
) (
  input logic CLK,
  input logic RST,
  brd_tx_ack_scheduler_if.master bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned GAP_W = 8;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [PTR_W-1:0] win;
  logic             prio_hit;

  // First set bit searching upward from ptr+1, wrapping modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                                input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] sel;
    logic             found;
    int unsigned      idx;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && pend[PTR_W'(idx)]) begin
        sel   = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    prio_hit = 1'b0;
`ifdef STATUS_PRIO_EN
    win = rr_pick(bus.PENDING & ~ONE, rr_ptr);
    if (bus.PENDING[0]) begin
      win      = '0;
      prio_hit = 1'b1;
    end
`else
    win = rr_pick(bus.PENDING, rr_ptr);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      rr_ptr         <= PTR_W'(NUM_REQ - 1);
      cnt            <= '0;
      gap_cnt        <= '0;
      bus.GRANT      <= '0;
      bus.TX_SEL     <= '0;
      bus.TX_START   <= 1'b0;
      bus.PENDING    <= '0;
      bus.SCHED_BUSY <= 1'b0;
      bus.TX_TIMEOUT <= 1'b0;
    end else begin
      bus.TX_START   <= 1'b0;
      bus.TX_TIMEOUT <= 1'b0;
      // A new request in the START cycle re-queues the source being served.
      bus.PENDING <= (bus.PENDING & ~(bus.TX_START ? bus.GRANT : '0)) | bus.REQ;

      case (state)
        IDLE: begin
          if ((|bus.PENDING) && !bus.TX_BUSY) begin
            state          <= ARB;
            bus.SCHED_BUSY <= 1'b1;
          end
        end
        ARB: begin
          if (|bus.PENDING) begin
            bus.GRANT    <= ONE << win;
            bus.TX_SEL   <= 3'(win);
            bus.TX_START <= 1'b1;
            if (!prio_hit) rr_ptr <= win;
            state <= START;
          end else begin
            state          <= IDLE;
            bus.SCHED_BUSY <= 1'b0;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.TX_DONE) begin
            bus.GRANT <= '0;
            gap_cnt   <= '0;
            state     <= GAP;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            bus.TX_TIMEOUT <= 1'b1;
            bus.GRANT      <= '0;
            gap_cnt        <= '0;
            state          <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (bus.OUT_TICK) begin
            if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
              gap_cnt        <= '0;
              state          <= IDLE;
              bus.SCHED_BUSY <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        default: begin
          state          <= IDLE;
          bus.GRANT      <= '0;
          bus.SCHED_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brd_tx_ack_scheduler.sv
// Bench for brd_tx_ack_scheduler: phase-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_brd_tx_ack_scheduler;

  localparam int NUM_REQ     = 5;
  localparam int GAP_TICKS   = 12;
  localparam int TIMEOUT_CYC = 2048;
`ifdef STATUS_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;

  brd_tx_ack_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  brd_tx_ack_scheduler #(
    .NUM_REQ(NUM_REQ), .GAP_TICKS(GAP_TICKS), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a phase name plus plain counters, advanced once per rising edge.
  string      m_phase = "idle";
  logic [4:0] m_pend  = '0;
  logic [4:0] m_grant = '0;
  logic [4:0] np;
  logic [2:0] m_sel   = '0;
  logic       m_start = 1'b0;
  logic       m_to    = 1'b0;
  int         m_last  = NUM_REQ - 1;
  int         m_age   = 0;
  int         m_ticks = 0;
  int         m_w;
  int         m_c;
  bit         chk_en  = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_phase = "idle"; m_pend = '0; m_grant = '0; m_sel = '0;
      m_start = 1'b0; m_to = 1'b0; m_last = NUM_REQ - 1; m_age = 0; m_ticks = 0;
      chk_en  = 1'b1;
    end else begin
      np      = (m_pend & ~(m_start ? m_grant : 5'b0)) | bus.REQ;
      m_start = 1'b0;
      m_to    = 1'b0;
      if (m_phase == "idle") begin
        if (m_pend != 0 && !bus.TX_BUSY) m_phase = "arb";
      end else if (m_phase == "arb") begin
        m_w = -1;
        if (PRIO && m_pend[0]) m_w = 0;
        else begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            m_c = (m_last + k) % NUM_REQ;
            if (m_w < 0 && m_pend[m_c] && !(PRIO && m_c == 0)) m_w = m_c;
          end
          if (m_w >= 0) m_last = m_w;
        end
        if (m_w < 0) m_phase = "idle";
        else begin
          m_grant = 5'(1) << m_w;
          m_sel   = 3'(m_w);
          m_start = 1'b1;
          m_phase = "start";
        end
      end else if (m_phase == "start") begin
        m_age   = 0;
        m_phase = "wait";
      end else if (m_phase == "wait") begin
        if (bus.TX_DONE) begin
          m_grant = '0; m_ticks = 0; m_phase = "gap";
        end else if (m_age == TIMEOUT_CYC - 1) begin
          m_to = 1'b1; m_grant = '0; m_ticks = 0; m_phase = "gap";
        end else m_age++;
      end else if (m_phase == "gap") begin
        if (bus.OUT_TICK) begin
          m_ticks++;
          if (m_ticks == GAP_TICKS) m_phase = "idle";
        end
      end
      m_pend = np;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("m_grant",   32'(bus.GRANT),      32'(m_grant));
      check("m_sel",     32'(bus.TX_SEL),     32'(m_sel));
      check("m_start",   32'(bus.TX_START),   32'(m_start));
      check("m_pending", 32'(bus.PENDING),    32'(m_pend));
      check("m_busy",    32'(bus.SCHED_BUSY), 32'(m_phase != "idle"));
      check("m_timeout", 32'(bus.TX_TIMEOUT), 32'(m_to));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_req(input logic [4:0] r);
    bus.REQ = r; cyc(1); bus.REQ = '0;
  endtask

  task automatic pulse_done();
    bus.TX_DONE = 1'b1; cyc(1); bus.TX_DONE = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      bus.OUT_TICK = 1'b1; cyc(1); bus.OUT_TICK = 1'b0; cyc(1);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (bus.TX_START !== 1'b1 && n < 400) begin
      cyc(1); n++;
    end
    check("start_seen", 32'(bus.TX_START), 32'd1);
  endtask

  // One full frame: grant, optional re-request in the START cycle, done, gap.
  task automatic serve(input int exp_sel, input logic [4:0] exp_pend, input logic [4:0] req_at_start);
    wait_start();
    check("serve_sel",   32'(bus.TX_SEL), 32'(exp_sel));
    check("serve_grant", 32'(bus.GRANT),  32'(5'(1) << exp_sel));
    bus.REQ = req_at_start; cyc(1); bus.REQ = '0;
    check("serve_pend",  32'(bus.PENDING), 32'(exp_pend));
    cyc(4);
    pulse_done();
    tick_n(GAP_TICKS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    bus.REQ = '0; bus.TX_DONE = 1'b0; bus.TX_BUSY = 1'b0; bus.OUT_TICK = 1'b0;
    cyc(3);
    check("rst_grant", 32'(bus.GRANT), 32'd0);
    check("rst_pend",  32'(bus.PENDING), 32'd0);
    check("rst_busy",  32'(bus.SCHED_BUSY), 32'd0);
    RST = 1'b0;

    // Single request: latency 3 to TX_START, done, 12-tick gap.
    pulse_req(5'b00100);
    check("t1_pend",   32'(bus.PENDING), 32'h04);
    check("t1_start0", 32'(bus.TX_START), 32'd0);
    cyc(1);
    check("t1_arb_busy", 32'(bus.SCHED_BUSY), 32'd1);
    check("t1_start1",   32'(bus.TX_START), 32'd0);
    cyc(1);
    check("t1_start", 32'(bus.TX_START), 32'd1);
    check("t1_sel",   32'(bus.TX_SEL), 32'd2);
    check("t1_grant", 32'(bus.GRANT), 32'h04);
    cyc(40);
    pulse_done();
    check("t1_grant_clr", 32'(bus.GRANT), 32'd0);
    pulse_done();
    tick_n(GAP_TICKS - 1);
    check("t1_gap_busy", 32'(bus.SCHED_BUSY), 32'd1);
    tick_n(1);
    check("t1_idle", 32'(bus.SCHED_BUSY), 32'd0);

    // All five at once from reset: order 0..4.
    RST = 1'b1; cyc(1); RST = 1'b0;
    pulse_req(5'b11111);
    serve(0, 5'b11110, 5'b0);
    serve(1, 5'b11100, 5'b0);
    serve(2, 5'b11000, 5'b0);
    serve(3, 5'b10000, 5'b0);
    serve(4, 5'b00000, 5'b0);

    // Re-request of index 1 during its own START cycle.
    pulse_req(5'b01110);
    serve(1, 5'b01110, 5'b00010);
    serve(2, 5'b01010, 5'b0);
    serve(3, 5'b00010, 5'b0);
    serve(1, 5'b00000, 5'b0);

    // Timeout on index 3, then index 0 is served.
    pulse_req(5'b01001);
    wait_start();
    check("t4_sel", 32'(bus.TX_SEL), 32'd3);
    cyc(1);
    cyc(TIMEOUT_CYC - 1);
    check("t4_no_to",  32'(bus.TX_TIMEOUT), 32'd0);
    check("t4_held",   32'(bus.GRANT), 32'h08);
    cyc(1);
    check("t4_to",     32'(bus.TX_TIMEOUT), 32'd1);
    check("t4_drop",   32'(bus.GRANT), 32'd0);
    cyc(1);
    check("t4_to_end", 32'(bus.TX_TIMEOUT), 32'd0);
    tick_n(GAP_TICKS);
    serve(0, 5'b00000, 5'b0);

    // Busy hold, release, then reset mid-frame.
    bus.TX_BUSY = 1'b1;
    pulse_req(5'b00010);
    cyc(100);
    check("t5_hold_busy", 32'(bus.SCHED_BUSY), 32'd0);
    check("t5_hold_pend", 32'(bus.PENDING), 32'h02);
    bus.TX_BUSY = 1'b0;
    cyc(2);
    check("t5_start", 32'(bus.TX_START), 32'd1);
    check("t5_sel",   32'(bus.TX_SEL), 32'd1);
    cyc(3);
    pulse_req(5'b10000);
    RST = 1'b1;
    cyc(1);
    check("t5_rst_grant", 32'(bus.GRANT), 32'd0);
    check("t5_rst_sel",   32'(bus.TX_SEL), 32'd0);
    check("t5_rst_start", 32'(bus.TX_START), 32'd0);
    check("t5_rst_pend",  32'(bus.PENDING), 32'd0);
    check("t5_rst_busy",  32'(bus.SCHED_BUSY), 32'd0);
    check("t5_rst_to",    32'(bus.TX_TIMEOUT), 32'd0);
    RST = 1'b0;

    // rr_ptr=0 with PENDING=10001.
    pulse_req(5'b00001);
    serve(0, 5'b00000, 5'b0);
    pulse_req(5'b10001);
`ifdef STATUS_PRIO_EN
    serve(0, 5'b10000, 5'b0);
    serve(4, 5'b00000, 5'b0);
`else
    serve(4, 5'b00001, 5'b0);
    serve(0, 5'b00000, 5'b0);
`endif
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
